// File: rtl/add_pkg.sv
// Shared constants and types for the serial 4-input adder.
package add_pkg;

  localparam int DATA_W_DFLT = 8;
  localparam int GROUP_N     = 4;

  // Sum width that holds GROUP_N maximal operands without overflow.
  function automatic int sum_w(input int data_w);
    return data_w + $clog2(GROUP_N);
  endfunction

  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/add_4_serial_if.sv
// Operand input stream and group-sum output stream of add_4_serial.
// o_avg exists only when ADD_4_SERIAL_AVG_EN is defined.
interface add_4_serial_if #(
  parameter int DATA_W = add_pkg::DATA_W_DFLT
);
  localparam int SUM_W = add_pkg::sum_w(DATA_W);

  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic              o_valid;
  logic [SUM_W-1:0]  o_sum;
  logic              i_ready;
`ifdef ADD_4_SERIAL_AVG_EN
  logic [DATA_W-1:0] o_avg;
`endif

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sum
`ifdef ADD_4_SERIAL_AVG_EN
    , output o_avg
`endif
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sum
`ifdef ADD_4_SERIAL_AVG_EN
    , input o_avg
`endif
  );

endinterface

// File: rtl/add_out_reg.sv
// Output holding register: loads a completed group sum, holds it until drained.
// With ADD_4_SERIAL_AVG_EN the rounded average is registered alongside.
module add_out_reg
  import add_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DFLT,
  localparam int SUM_W  = sum_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [SUM_W-1:0]  sum_o
`ifdef ADD_4_SERIAL_AVG_EN
  , output logic [DATA_W-1:0] avg_o
`endif
);

  logic             valid_q;
  logic [SUM_W-1:0] sum_q;

  // A load while full only happens when the old value drains the same cycle,
  // so load always wins over drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      sum_q   <= sum_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;

`ifdef ADD_4_SERIAL_AVG_EN
  logic [DATA_W-1:0] avg_q;
  logic [SUM_W-1:0]  rounded;

  // Round half up; 4*max+2 still fits in SUM_W bits.
  assign rounded = sum_i + {{(SUM_W-2){1'b0}}, 2'd2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q <= '0;
    end else if (load_i) begin
      avg_q <= DATA_W'(rounded >> 2);
    end
  end

  assign avg_o = avg_q;
`endif

endmodule

// File: rtl/add_4_serial.sv
// Serial adder: sums every group of 4 accepted operands onto a registered stream.
// Define ADD_4_SERIAL_AVG_EN to also output the rounded group average.
module add_4_serial
  import add_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DFLT,
  localparam int SUM_W  = sum_w(DATA_W)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clear,
  add_4_serial_if.slave   s
);

  cnt_t             cnt_q, cnt_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] grp_sum;
  logic             last;
  logic             take;
  logic             load;

  assign last    = (cnt_q == cnt_t'(GROUP_N - 1));
  // Only the completing operand stalls, and only if the old sum cannot leave.
  assign s.o_ready = ~(last & s.o_valid & ~s.i_ready);
  assign take    = s.i_valid & s.o_ready & ~i_clear;
  assign grp_sum = acc_q + {{(SUM_W-DATA_W){1'b0}}, s.i_data};
  assign load    = take & last;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = grp_sum;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; blocking here
  // would make the result depend on process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  add_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load_i  (load),
    .sum_i   (grp_sum),
    .ready_i (s.i_ready),
    .valid_o (s.o_valid),
    .sum_o   (s.o_sum)
`ifdef ADD_4_SERIAL_AVG_EN
    , .avg_o (s.o_avg)
`endif
  );

endmodule
